iomem_uart: RTL
===============

# iomem_uart

Memory-mapped UART responder on the SoC `iomem` bus. It is the target end of the CPU's `iomem_valid`/`iomem_ready` handshake and decodes a 16-byte window at `BASE_ADDR`. It serialises TX bytes, deserialises RX bytes into a holding buffer, and drives a level interrupt into one of the SoC's external IRQ inputs (`irq_5..7`).

## Interface
- `BASE_ADDR`, default 32'h1000_0000: window base; decode uses bits [31:4].
- `DEFAULT_DIV`, default 104: reset value of CLKDIV, in clk cycles per bit.
- `clk`  in  1: single clock; all logic on its rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `iomem_valid`  in  1: bus request.
- `iomem_ready`  out  1: one-cycle completion pulse.
- `iomem_wstrb`  in  4: byte write strobes; 0 means read.
- `iomem_addr`  in  32: byte address.
- `iomem_wdata`  in  32: write data.
- `iomem_rdata`  out  32: read data; valid only while `iomem_ready`=1, otherwise 0.
- `ser_rx`  in  1: asynchronous serial input.
- `ser_tx`  out  1: serial output; idle high.
- `irq`  out  1: level high while RX data is available.

## Operation
- `sel` = `iomem_valid && iomem_addr[31:4] == BASE_ADDR[31:4]`. Bus traffic outside the window is ignored.
- Register map:
  - 0x0 CLKDIV (R/W, 32-bit, byte-strobed).
  - 0x4 DATA.
  - 0x8 STATUS.
  - 0xC reads 0; writes are ignored; access is still acknowledged.
- DATA write (`wstrb[0]`=1): loads `wdata[7:0]` into TX and starts a frame.
- DATA read (`wstrb`=0):
  - RX data available: returns {24'h0, byte} and pops it.
  - Otherwise: returns 32'hFFFF_FFFF with no side effect.
- STATUS bits:
  - [0] rx_avail.
  - [1] tx_busy.
  - [2] overrun (sticky).
  - [3] frame_err (sticky).
  - Writing 1 to bits 2 or 3 via `wstrb[0]` clears them. Other bits read 0.
- Bit period = max(CLKDIV, 2) cycles. Counters reload from CLKDIV at each bit boundary, so a CLKDIV write mid-frame takes effect from the next bit.
- TX state machine: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE. Each state lasts one bit period; the frame is 10 bit periods. tx_busy=1 outside IDLE.
- RX path:
  - `ser_rx` passes through a 2-flop synchroniser.
  - IDLE: a falling edge enters START.
  - START: wait period/2 and resample. If high (false start), return to IDLE. If low, enter DATA.
  - DATA: sample 8 bits at full-period spacing.
  - STOP: sample stop bit. If 1, push the byte. If 0, set frame_err and discard the byte. Return to IDLE.
- Push when buffer full: set overrun and drop the new byte. Pop and push in the same cycle on a full buffer: both succeed, no overrun.
- `irq` = rx_avail.
- Reset values:
  - `iomem_ready`=0, `iomem_rdata`=0, `ser_tx`=1, `irq`=0.
  - CLKDIV=DEFAULT_DIV.
  - Buffer empty; all flags 0; both state machines in IDLE.
- Reset mid-frame aborts immediately. `ser_tx` returns high asynchronously.

## Timing
- Read or non-blocking write: `sel` in cycle N → `iomem_ready`=1 with `iomem_rdata` in cycle N+1 → `iomem_ready`=0 in N+2, even if `iomem_valid` is still high.
- The initiator holds `valid`, `addr`, `wdata` and `wstrb` stable until ready. A new access may be accepted from cycle N+2.
- DATA write while tx_busy: `iomem_ready` is withheld until TX reaches IDLE. The write is accepted in that IDLE cycle and ready follows one cycle later. This is back-pressure only; no data is lost.
- The first start-bit edge on `ser_tx` appears 1 cycle after the write is accepted.
- RX byte is visible in STATUS[0] and `irq` 1 cycle after the stop-bit sample.
- `irq` deasserts 1 cycle after the pop that empties the buffer.

## Configuration
- `IOMEM_UART_RXFIFO_EN` defined: RX buffer is a 4-entry FIFO with wrap-around pointers. Overrun is set only on a push into 4 stored bytes.
- Not defined: RX buffer is a single-byte holding register. Overrun is set on any push while rx_avail=1. All other behaviour is identical.

## Test plan
- Reset → `ser_tx`=1, `irq`=0. Read 0x0 returns 104. Read 0x4 returns FFFF_FFFF. Read 0x8 returns 0.
- Write CLKDIV=8, then write DATA=0x5A → `ser_tx` low for 8 cycles, then bits 0,1,0,1,1,0,1,0 at 8 cycles each, then high. tx_busy=1 for 80 cycles.
- Second DATA write issued during a frame → `iomem_ready` stays low until the first frame ends. Second frame carries the second byte.
- Drive 0xA3 at CLKDIV=8 on `ser_rx` → `irq`=1. DATA read returns 0x0000_00A3 and `irq` drops next cycle. 3-cycle low glitch on `ser_rx` → nothing received.
- Stop bit driven 0 → STATUS=0x8 and no byte. Write 0x8 to STATUS → STATUS reads 0.
- Send 5 bytes without reading → with `IOMEM_UART_RXFIFO_EN`: 4 readable, overrun=1. Without: first byte readable, overrun=1.

Source files
------------

// File: rtl/iomem_uart_if.sv
// iomem bus bundle between the CPU (master) and the UART responder (slave).
interface iomem_uart_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_uart.sv
// Memory-mapped UART on the iomem bus: CLKDIV / DATA / STATUS registers,
// 8N1 TX and RX, level irq while RX data is waiting.
// Optional macro IOMEM_UART_RXFIFO_EN: 4-entry RX FIFO instead of a
// single-byte holding register.
module iomem_uart #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter logic [31:0] DEFAULT_DIV = 32'd104
) (
  input  logic       clk,
  input  logic       resetn,
  iomem_uart_if.slave bus,
  input  logic       ser_rx,
  output logic       ser_tx,
  output logic       irq
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_e;

  logic [31:0] clkdiv, period, half;
  logic        ready;
  logic [31:0] rdata;
  logic        overrun, frame_err;

  uart_st_e    tx_st;
  logic [31:0] tx_cnt;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_bit;

  uart_st_e    rx_st;
  logic [31:0] rx_cnt;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bit;
  logic        rx_s1, rx_s2, rx_s3;

  logic        rx_avail, full, push_req, frame_bad, do_push;
  logic [7:0]  rx_head;

  // Bit period never drops below 2 so half-period sampling stays meaningful.
  assign period = (clkdiv < 32'd2) ? 32'd2 : clkdiv;
  assign half   = period >> 1;

  logic       sel, is_rd, stall, acc, tx_start, pop, tx_busy;
  logic [1:0] reg_idx;
  logic       unused_addr;

  assign sel      = bus.iomem_valid && (bus.iomem_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_idx  = bus.iomem_addr[3:2];
  assign is_rd    = (bus.iomem_wstrb == 4'h0);
  assign tx_busy  = (tx_st != S_IDLE);
  // A DATA write stalls while a frame is on the wire; it lands in the idle cycle.
  assign stall    = (reg_idx == 2'd1) && bus.iomem_wstrb[0] && tx_busy;
  // ready high means the current access was taken last cycle; do not retake it.
  assign acc      = sel && !ready && !stall;
  assign tx_start = acc && (reg_idx == 2'd1) && bus.iomem_wstrb[0];
  assign pop      = acc && is_rd && (reg_idx == 2'd1) && rx_avail;
  assign unused_addr = &{1'b0, bus.iomem_addr[1:0]};

  assign push_req  = (rx_st == S_STOP) && (rx_cnt == 32'd0) && rx_s2;
  assign frame_bad = (rx_st == S_STOP) && (rx_cnt == 32'd0) && !rx_s2;
  // A simultaneous pop frees a slot, so a push into a full buffer still lands.
  assign do_push   = push_req && (!full || pop);

  assign bus.iomem_ready = ready;
  assign bus.iomem_rdata = rdata;
  assign irq             = rx_avail;

  // Bus response, register reads and byte-strobed CLKDIV writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready  <= 1'b0;
      rdata  <= '0;
      clkdiv <= DEFAULT_DIV;
    end else begin
      ready <= acc;
      rdata <= '0;
      if (acc) begin
        if (is_rd) begin
          case (reg_idx)
            2'd0:    rdata <= clkdiv;
            2'd1:    rdata <= rx_avail ? {24'h0, rx_head} : 32'hFFFF_FFFF;
            2'd2:    rdata <= {28'h0, frame_err, overrun, tx_busy, rx_avail};
            default: rdata <= '0;
          endcase
        end else if (reg_idx == 2'd0) begin
          for (int i = 0; i < 4; i++)
            if (bus.iomem_wstrb[i]) clkdiv[8*i +: 8] <= bus.iomem_wdata[8*i +: 8];
        end
      end
    end
  end

  // Sticky error flags; a new event in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (acc && (reg_idx == 2'd2) && bus.iomem_wstrb[0]) begin
        if (bus.iomem_wdata[2]) overrun   <= 1'b0;
        if (bus.iomem_wdata[3]) frame_err <= 1'b0;
      end
      if (push_req && full && !pop) overrun   <= 1'b1;
      if (frame_bad)                frame_err <= 1'b1;
    end
  end

`ifdef IOMEM_UART_RXFIFO_EN
  logic [7:0] fifo [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;

  assign rx_avail = (cnt != 3'd0);
  assign full     = (cnt == 3'd4);
  assign rx_head  = fifo[rp];

  // FIFO storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (do_push) fifo[wp] <= rx_shift;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 2'd1;
      if (pop)     rp <= rp + 2'd1;
      cnt <= cnt + {2'b0, do_push} - {2'b0, pop};
    end
  end
`else
  logic [7:0] hold;
  logic       avail;

  assign rx_avail = avail;
  assign full     = avail;
  assign rx_head  = hold;

  // Single-byte holding register; a push in the pop cycle keeps it full.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold  <= '0;
      avail <= 1'b0;
    end else if (do_push) begin
      hold  <= rx_shift;
      avail <= 1'b1;
    end else if (pop) begin
      avail <= 1'b0;
    end
  end
`endif

  // TX framing: start, 8 data LSB first, stop; ser_tx registered, idle high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_st    <= S_IDLE;
      ser_tx   <= 1'b1;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
    end else begin
      case (tx_st)
        S_IDLE: begin
          ser_tx <= 1'b1;
          if (tx_start) begin
            tx_st    <= S_START;
            ser_tx   <= 1'b0;
            tx_shift <= bus.iomem_wdata[7:0];
            tx_cnt   <= period - 32'd1;
          end
        end
        S_START: begin
          if (tx_cnt == 32'd0) begin
            tx_st  <= S_DATA;
            ser_tx <= tx_shift[0];
            tx_bit <= '0;
            tx_cnt <= period - 32'd1;
          end else tx_cnt <= tx_cnt - 32'd1;
        end
        S_DATA: begin
          if (tx_cnt == 32'd0) begin
            tx_cnt <= period - 32'd1;
            tx_bit <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) begin
              tx_st  <= S_STOP;
              ser_tx <= 1'b1;
            end else begin
              ser_tx   <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else tx_cnt <= tx_cnt - 32'd1;
        end
        S_STOP: begin
          if (tx_cnt == 32'd0) tx_st <= S_IDLE;
          else                 tx_cnt <= tx_cnt - 32'd1;
        end
        default: tx_st <= S_IDLE;
      endcase
    end
  end

  // RX: synchronise, detect start edge, sample mid-bit, check stop bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_st    <= S_IDLE;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      rx_s1 <= ser_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      case (rx_st)
        S_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_st  <= S_START;
            rx_cnt <= half - 32'd1;
          end
        end
        S_START: begin
          if (rx_cnt == 32'd0) begin
            if (rx_s2) rx_st <= S_IDLE;
            else begin
              rx_st  <= S_DATA;
              rx_bit <= '0;
              rx_cnt <= period - 32'd1;
            end
          end else rx_cnt <= rx_cnt - 32'd1;
        end
        S_DATA: begin
          if (rx_cnt == 32'd0) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            rx_cnt   <= period - 32'd1;
            if (rx_bit == 3'd7) rx_st <= S_STOP;
          end else rx_cnt <= rx_cnt - 32'd1;
        end
        S_STOP: begin
          if (rx_cnt == 32'd0) rx_st <= S_IDLE;
          else                 rx_cnt <= rx_cnt - 32'd1;
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

endmodule
